check_1111: RTL and testbench

Serial pattern detector that watches a one-bit input stream and flags every occurrence of four consecutive `1` bits, overlapping occurrences included. It is a small Moore state machine in a single clock domain. It sits directly behind a serial bit source and drives a one-bit "pattern found" flag to downstream logic. The output is decoded from registered state only, so there is no combinational path from `x` to `z`.

---
 rtl/check_1111_pkg.sv | 16 +
 rtl/check_1111.sv | 38 +++
 tb/tb_check_1111.sv | 90 +++++++++
 3 files changed

// File: rtl/check_1111_pkg.sv
// Shared types for the 1111 serial pattern detector.
// State encoding and the detected run length.
package check_1111_pkg;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } state_t;

    // The FSM below is hard-wired to this length.
    localparam int RUN_LEN = 4;

endpackage

// File: rtl/check_1111.sv
// Moore detector: z is high while the last four sampled bits are 1.
// Overlapping runs keep z high; any 0 returns to S0.
module check_1111
    import check_1111_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // Illegal encodings fall through to S0 via the default.
    always_comb begin
        state_nxt = S0;
        unique case (state)
            S0: state_nxt = x ? S1 : S0;
            S1: state_nxt = x ? S2 : S0;
            S2: state_nxt = x ? S3 : S0;
            S3: state_nxt = x ? S4 : S0;
            S4: state_nxt = x ? S4 : S0;
            default: state_nxt = S0;
        endcase
    end

    assign z = (state == S4);

endmodule

// File: tb/tb_check_1111.sv
// Directed bench for check_1111 with a run-length reference
// model feeding an expected-value queue.
module tb_check_1111;

    logic clk;
    logic rst;
    logic x;
    logic z;

    int   ncmp;
    int   nfail;
    int   cnt;
    bit   expq[$];

    check_1111 dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge, predict z, then compare just after the edge.
    task automatic step(input string tag, input logic r, input logic b);
        bit e;
        rst = r;
        x   = b;
        if (r)
            cnt = 0;
        else if (b)
            cnt = (cnt < 4) ? cnt + 1 : 4;
        else
            cnt = 0;
        expq.push_back(cnt == 4);
        @(posedge clk);
        #1;
        ncmp++;
        if (expq.size() == 0) begin
            nfail++;
            $error("FAIL %s: queue empty, z=%b", tag, z);
        end else begin
            e = expq.pop_front();
            assert (z === e) else begin
                nfail++;
                $error("FAIL %s: z=%b expected=%b", tag, z, e);
            end
        end
    endtask

    // Feed n bits of v, MSB first, with reset low.
    task automatic run(input string tag, input logic [31:0] v,
                       input int n);
        for (int i = n - 1; i >= 0; i--)
            step(tag, 1'b0, v[i]);
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        cnt   = 0;
        rst   = 1'b1;
        x     = 1'b1;
        #2;

        step("reset0", 1'b1, 1'b1);
        step("reset1", 1'b1, 1'b1);
        run("release", 32'b11110, 5);

        run("exact4", 32'b011110, 6);
        run("overlap", 32'b11111110, 8);
        run("nearmiss", 32'b11101110, 8);

        for (int k = 0; k < 3; k++)
            run("rotate", 32'hC3D67B, 24);

        run("idle", 32'b0, 1);
        run("midrun", 32'b111, 3);
        step("midrst", 1'b1, 1'b1);
        run("postrst", 32'b111, 3);
        run("fourth", 32'b1, 1);
        run("clear", 32'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
